exec_cc_stage: RTL and testbench

- Y-86 pipeline execute-stage back end: the consumer of the 64-bit ALU's result/overflow outputs.
- Latches the ALU outcome into the E→M pipeline register.
- Maintains the architectural condition-code register (ZF, SF, OF).
- Evaluates the jXX/cmovXX condition (Cnd) against the CC state.
- Uses a valid/ready handshake on both sides so the memory stage can stall it.

---
 rtl/exec_cc_stage.sv | 110 +++++++++++
 tb/tb_exec_cc_stage.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_cc_stage.sv
// Y-86 execute-stage back end: E->M pipeline register,
// condition-code register and jXX/cmovXX condition evaluation.
module exec_cc_stage #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  input  logic             set_cc,
  input  logic [3:0]       cond_fn,
  input  logic             mw_exc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [1:0]       out_control,
  output logic             out_cnd,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [1:0]       control_q, control_d;
  logic             cnd_q, cnd_d;
  logic             zf_q, zf_d;
  logic             sf_q, sf_d;
  logic             of_q, of_d;
  logic             acc;
  logic             lt;
  logic             cnd;

  assign in_ready = !valid_q || out_ready;
  assign acc      = in_valid && in_ready && !flush;

  // Condition sees the CC value before this cycle's update.
  always_comb begin
    lt = sf_q ^ of_q;
    case (cond_fn)
      4'd0:    cnd = 1'b1;
      4'd1:    cnd = lt | zf_q;
      4'd2:    cnd = lt;
      4'd3:    cnd = zf_q;
      4'd4:    cnd = !zf_q;
      4'd5:    cnd = !lt;
      4'd6:    cnd = !lt && !zf_q;
      default: cnd = 1'b0;
    endcase
  end

  always_comb begin
    valid_d   = valid_q;
    result_d  = result_q;
    control_d = control_q;
    cnd_d     = cnd_q;
    zf_d      = zf_q;
    sf_d      = sf_q;
    of_d      = of_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (acc) begin
      valid_d   = 1'b1;
      result_d  = alu_result;
      control_d = alu_control;
      cnd_d     = cnd;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
    // Overflow only means something for add/sub.
    if (acc && set_cc && !mw_exc) begin
      zf_d = (alu_result == '0);
      sf_d = alu_result[WIDTH-1];
      of_d = !alu_control[1] && alu_overflow;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      result_q  <= '0;
      control_q <= 2'd0;
      cnd_q     <= 1'b0;
      zf_q      <= 1'b1;
      sf_q      <= 1'b0;
      of_q      <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      result_q  <= result_d;
      control_q <= control_d;
      cnd_q     <= cnd_d;
      zf_q      <= zf_d;
      sf_q      <= sf_d;
      of_q      <= of_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_result  = result_q;
  assign out_control = control_q;
  assign out_cnd     = cnd_q;
  assign cc_zf       = zf_q;
  assign cc_sf       = sf_q;
  assign cc_of       = of_q;

endmodule

// File: tb/tb_exec_cc_stage.sv
// Self-checking bench for exec_cc_stage: directed scenarios
// plus a randomized run against a behavioural reference model.
module tb_exec_cc_stage;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   alu_control;
  logic [W-1:0] alu_result;
  logic         alu_overflow;
  logic         set_cc;
  logic [3:0]   cond_fn;
  logic         mw_exc;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic [1:0]   out_control;
  logic         out_cnd;
  logic         cc_zf, cc_sf, cc_of;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit         m_valid;
  bit [W-1:0] m_res;
  bit [1:0]   m_ctl;
  bit         m_cnd;
  bit         m_zf, m_sf, m_of;

  always #5 clk = ~clk;

  exec_cc_stage #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .alu_result(alu_result),
    .alu_overflow(alu_overflow), .set_cc(set_cc),
    .cond_fn(cond_fn), .mw_exc(mw_exc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_control(out_control),
    .out_cnd(out_cnd),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  // Branch condition in terms of signed-compare meaning:
  // "less" is SF!=OF, "equal" is ZF.
  function automatic bit cond_ok(input bit [3:0] f,
                                 input bit zf, sf, of);
    bit less;
    less = (sf != of);
    case (f)
      4'd0: return 1'b1;
      4'd1: return less || zf;
      4'd2: return less;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return !less;
      4'd6: return !less && !zf;
      default: return 1'b0;
    endcase
  endfunction

  // Advance the model with the inputs present now, then clock.
  task automatic step();
    bit rdy, acc, c;
    rdy = !m_valid || out_ready;
    acc = in_valid && rdy && !flush;
    c   = cond_ok(cond_fn, m_zf, m_sf, m_of);
    if (reset) begin
      m_valid = 0; m_res = '0; m_ctl = 0; m_cnd = 0;
      m_zf = 1; m_sf = 0; m_of = 0;
    end else begin
      if (acc && set_cc && !mw_exc) begin
        m_zf = (alu_result == 0);
        m_sf = alu_result[W-1];
        m_of = (alu_control <= 2'd1) ? alu_overflow : 1'b0;
      end
      if (flush) m_valid = 0;
      else if (acc) begin
        m_valid = 1; m_res = alu_result;
        m_ctl = alu_control; m_cnd = c;
      end else if (out_ready) m_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; in_valid = 0; alu_control = 0;
    alu_result = '0; alu_overflow = 0; set_cc = 0;
    cond_fn = 0; mw_exc = 0; flush = 0; out_ready = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    step(); step();
    reset = 0;
    checks++;
    if ({out_valid, out_result, out_control, out_cnd}
        !== {1'b0, 64'd0, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_out: got v=%0b r=%h c=%0d cnd=%0b want 0",
               out_valid, out_result, out_control, out_cnd);
    end
    checks++;
    if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin
      errors++;
      $display("FAIL reset_cc: got %b want 100",
               {cc_zf, cc_sf, cc_of});
    end
  endtask

  task automatic test_add_zero();
    idle_inputs();
    in_valid = 1; set_cc = 1;
    step();
    in_valid = 0; set_cc = 0;
    checks++;
    if ({out_valid, out_result} !== {1'b1, 64'd0}) begin
      errors++;
      $display("FAIL add_zero_out: got v=%0b r=%h want v=1 r=0",
               out_valid, out_result);
    end
    checks++;
    if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin
      errors++;
      $display("FAIL add_zero_cc: got %b want 100",
               {cc_zf, cc_sf, cc_of});
    end
  endtask

  task automatic test_overflow();
    idle_inputs();
    in_valid = 1; set_cc = 1; alu_overflow = 1;
    alu_result = 64'hFFFF_FFFF_FFFF_FFFE;
    step();
    checks++;
    if ({cc_zf, cc_sf, cc_of} !== 3'b011) begin
      errors++;
      $display("FAIL ovf_cc: got %b want 011",
               {cc_zf, cc_sf, cc_of});
    end
    set_cc = 0; alu_overflow = 0; cond_fn = 2;
    step();
    checks++;
    if (out_cnd !== 1'b0) begin
      errors++;
      $display("FAIL ovf_cnd_l: got %0b want 0", out_cnd);
    end
    cond_fn = 1;
    step();
    checks++;
    if (out_cnd !== 1'b0) begin
      errors++;
      $display("FAIL ovf_cnd_le: got %0b want 0", out_cnd);
    end
    cond_fn = 5;
    step();
    checks++;
    if (out_cnd !== 1'b1) begin
      errors++;
      $display("FAIL ovf_cnd_ge: got %0b want 1", out_cnd);
    end
  endtask

  task automatic test_xor();
    idle_inputs();
    in_valid = 1; set_cc = 1; alu_overflow = 1;
    alu_control = 3;
    alu_result = 64'h7FFF_FFFF_FFFF_FFFB;
    step();
    checks++;
    if ({cc_zf, cc_sf, cc_of, out_control} !== 5'b000_11) begin
      errors++;
      $display("FAIL xor_cc: got cc=%b ctl=%0d want cc=000 ctl=3",
               {cc_zf, cc_sf, cc_of}, out_control);
    end
    set_cc = 0; cond_fn = 6;
    step();
    checks++;
    if (out_cnd !== 1'b1) begin
      errors++;
      $display("FAIL xor_cnd_g: got %0b want 1", out_cnd);
    end
    cond_fn = 9;
    step();
    checks++;
    if (out_cnd !== 1'b0) begin
      errors++;
      $display("FAIL xor_cnd_9: got %0b want 0", out_cnd);
    end
  endtask

  task automatic test_stall();
    idle_inputs();
    in_valid = 1; alu_result = 64'h1234;
    step();
    // Next op is a sub giving zero; it must wait out the stall.
    out_ready = 0; alu_result = '0; alu_control = 1;
    set_cc = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({in_ready, out_valid, out_result} !== {1'b0, 1'b1, 64'h1234}
          || {cc_zf, cc_sf, cc_of} !== 3'b000) begin
        errors++;
        $display("FAIL stall_hold%0d: got rdy=%0b v=%0b r=%h cc=%b want 0 1 1234 000",
                 i, in_ready, out_valid, out_result,
                 {cc_zf, cc_sf, cc_of});
      end
    end
    out_ready = 1;
    step();
    in_valid = 0; set_cc = 0;
    checks++;
    if ({out_valid, out_result, out_control} !== {1'b1, 64'd0, 2'd1}
        || {cc_zf, cc_sf, cc_of} !== 3'b100) begin
      errors++;
      $display("FAIL stall_fill: got v=%0b r=%h c=%0d cc=%b want 1 0 1 100",
               out_valid, out_result, out_control,
               {cc_zf, cc_sf, cc_of});
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain: got v=%0b want 0", out_valid);
    end
  endtask

  task automatic test_inhibit_flush();
    idle_inputs();
    in_valid = 1; set_cc = 1; alu_control = 2;
    alu_result = 64'h8000_0000_0000_0000;
    step();
    alu_result = '0; alu_control = 0; mw_exc = 1;
    step();
    checks++;
    if ({out_valid, cc_zf, cc_sf, cc_of} !== 4'b1_010) begin
      errors++;
      $display("FAIL inhibit: got v=%0b cc=%b want 1 010",
               out_valid, {cc_zf, cc_sf, cc_of});
    end
    mw_exc = 0; set_cc = 0; out_ready = 0;
    alu_result = 64'h55;
    step();
    flush = 1; set_cc = 1; alu_result = '0;
    step();
    checks++;
    if ({out_valid, cc_zf, cc_sf, cc_of} !== 4'b0_010) begin
      errors++;
      $display("FAIL flush: got v=%0b cc=%b want 0 010",
               out_valid, {cc_zf, cc_sf, cc_of});
    end
    idle_inputs();
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop: got v=%0b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_stall();
    idle_inputs();
    in_valid = 1; set_cc = 1; alu_result = 64'h99;
    alu_control = 2; cond_fn = 0;
    step();
    out_ready = 0;
    step();
    reset = 1;
    step();
    reset = 0; in_valid = 0;
    checks++;
    if ({out_valid, out_result, out_control, out_cnd,
         cc_zf, cc_sf, cc_of} !== {1'b0, 64'd0, 2'd0, 1'b0, 3'b100}) begin
      errors++;
      $display("FAIL reset_stall: got v=%0b r=%h c=%0d cnd=%0b cc=%b want 0 0 0 0 100",
               out_valid, out_result, out_control, out_cnd,
               {cc_zf, cc_sf, cc_of});
    end
  endtask

  task automatic test_random();
    bit [W-1:0] r;
    for (int i = 0; i < 400; i++) begin
      reset        = ($urandom_range(0, 39) == 0);
      flush        = ($urandom_range(0, 7) == 0);
      mw_exc       = ($urandom_range(0, 3) == 0);
      in_valid     = ($urandom_range(0, 3) != 0);
      out_ready    = $urandom_range(0, 1);
      set_cc       = $urandom_range(0, 1);
      alu_control  = 2'($urandom_range(0, 3));
      alu_overflow = $urandom_range(0, 1);
      cond_fn      = 4'($urandom_range(0, 15));
      r = {32'($urandom), 32'($urandom)};
      case ($urandom_range(0, 3))
        0: r = '0;
        1: r[W-1] = 1'b1;
        default: ;
      endcase
      alu_result = r;
      #1;
      checks++;
      if (in_ready !== (!m_valid || out_ready)) begin
        errors++;
        $display("FAIL rnd_ready%0d: got %0b want %0b",
                 i, in_ready, !m_valid || out_ready);
      end
      step();
      checks++;
      if ({out_valid, out_result, out_control, out_cnd,
           cc_zf, cc_sf, cc_of} !==
          {m_valid, m_res, m_ctl, m_cnd, m_zf, m_sf, m_of}) begin
        errors++;
        $display("FAIL rnd_state%0d: got v=%0b r=%h c=%0d cnd=%0b cc=%b want v=%0b r=%h c=%0d cnd=%0b cc=%b",
                 i, out_valid, out_result, out_control, out_cnd,
                 {cc_zf, cc_sf, cc_of}, m_valid, m_res, m_ctl,
                 m_cnd, {m_zf, m_sf, m_of});
      end
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_add_zero();
    test_overflow();
    test_xor();
    test_stall();
    test_inhibit_flush();
    test_reset_mid_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
